if_fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. Owns the program counter, runs a single-outstanding request/acknowledge handshake with instruction memory, and presents the fetched instruction and its PC to IF/ID. Also absorbs load-use stalls and branch redirects from later stages, and raises the IF/ID flush.

---
 rtl/if_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
// runs a single-outstanding req/ack handshake with instruction memory, holds
// the fetched word for IF/ID, absorbs hazard stalls and branch redirects and
// raises a one-cycle IF/ID flush after every redirect.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   hazDetect_PC   in   1 = consume held instruction and fetch next, 0 = hold
//   branch_taken   in   redirect request from EX
//   branch_target  in   redirect address (32)
//   imem_req       out  instruction memory request
//   imem_addr      out  address of the outstanding request (32)
//   imem_ack       in   memory acknowledge, imem_rdata valid same cycle
//   imem_rdata     in   instruction word (32)
//   pc_o           out  PC of the instruction on inst_o (32)
//   inst_o         out  held instruction, NOP_INST when not valid (32)
//   inst_valid_o   out  inst_o holds a real fetched instruction
//   IF_Flush       out  one-cycle flush pulse to IF/ID
//   misalign_o     out  sticky misaligned-target flag (PC_MISALIGN_CHK_EN only)
//
// Build option
//   PC_MISALIGN_CHK_EN : a redirect to a non-word-aligned target raises
//                        misalign_o and parks the unit in HALT until reset.
//                        Without it the target's low two bits are cleared.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazDetect_PC,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        IF_Flush
`ifdef PC_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

`ifdef PC_MISALIGN_CHK_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_READY, S_KILL, S_HALT} state_t;
  logic        misalign_q, misalign_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READY, S_KILL} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] inst_q, inst_d;
  logic        flush_q, flush_d;
  logic [31:0] tgt_pc;

`ifdef PC_MISALIGN_CHK_EN
  assign tgt_pc = branch_target;
`else
  assign tgt_pc = branch_target & ~32'h3;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    inst_d      = inst_q;
    flush_d     = branch_taken;
`ifdef PC_MISALIGN_CHK_EN
    misalign_d  = misalign_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (branch_taken) pc_d = tgt_pc;
      end
      S_FETCH: begin
        if (branch_taken) begin
          pc_d = tgt_pc;
          if (!imem_ack) begin
            // Stale request still in flight: remember its address so the
            // bus stays stable until memory acknowledges it.
            state_d     = S_KILL;
            kill_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (branch_taken) begin
          pc_d    = tgt_pc;
          state_d = S_FETCH;
        end else if (hazDetect_PC) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_KILL: begin
        if (branch_taken) pc_d = tgt_pc;
        if (imem_ack) state_d = S_FETCH;
      end
`ifdef PC_MISALIGN_CHK_EN
      S_HALT: flush_d = 1'b0;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef PC_MISALIGN_CHK_EN
    // A misaligned redirect overrides everything above and abandons any
    // outstanding request.
    if (state_q != S_HALT && branch_taken && branch_target[1:0] != 2'b00) begin
      state_d    = S_HALT;
      pc_d       = pc_q;
      misalign_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
`ifdef PC_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Data-only registers; they are never observed before being written.
  always_ff @(posedge clk) begin
    kill_addr_q <= kill_addr_d;
    inst_q      <= inst_d;
  end

  assign imem_req     = (state_q == S_FETCH) || (state_q == S_KILL);
  assign imem_addr    = (state_q == S_KILL) ? kill_addr_q : pc_q;
  assign inst_valid_o = (state_q == S_READY);
  assign inst_o       = (state_q == S_READY) ? inst_q : NOP_INST;
  assign pc_o         = pc_q;
  assign IF_Flush     = flush_q;
`ifdef PC_MISALIGN_CHK_EN
  assign misalign_o   = misalign_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazDetect_PC, branch_taken, imem_ack;
  logic [31:0] branch_target;
  logic        imem_req, inst_valid_o, IF_Flush;
  logic [31:0] imem_addr, imem_rdata, pc_o, inst_o;
`ifdef PC_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem(imem_addr);

  if_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hazDetect_PC (hazDetect_PC),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .IF_Flush     (IF_Flush)
`ifdef PC_MISALIGN_CHK_EN
    ,
    .misalign_o   (misalign_o)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          br;
    logic [31:0] tgt;
    bit          haz;
    bit          ack;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_flush;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(bit br, logic [31:0] tgt, bit haz, bit ack,
                              bit er, logic [31:0] ea, bit ev, logic [31:0] ep, bit ef);
    vec_t v;
    v.br = br; v.tgt = tgt; v.haz = haz; v.ack = ack;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_flush = ef;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  // Tracks "is a request outstanding, is it wrong-path, is an instruction held".
  logic [31:0] m_pc, m_oaddr, m_inst;
  bit          m_idle, m_out, m_stale, m_held, m_flush, m_halt, m_mis;

  task automatic m_reset();
    m_pc = 32'h0; m_oaddr = 32'h0; m_inst = NOP;
    m_idle = 1; m_out = 0; m_stale = 0; m_held = 0;
    m_flush = 0; m_halt = 0; m_mis = 0;
  endtask

  task automatic m_step(input bit br, input logic [31:0] tgt, input bit haz, input bit ack);
    logic [31:0] t;
    if (m_halt) begin
      m_flush = 0;
      return;
    end
    m_flush = br;
`ifdef PC_MISALIGN_CHK_EN
    t = tgt;
    if (br && tgt[1:0] != 2'b00) begin
      m_halt = 1; m_mis = 1; m_out = 0; m_held = 0; m_idle = 0;
      return;
    end
`else
    t = tgt & ~32'h3;
`endif
    if (m_idle) begin
      m_idle = 0;
      if (br) m_pc = t;
      m_out = 1; m_stale = 0; m_oaddr = m_pc;
    end else if (br) begin
      m_pc = t; m_held = 0;
      if (m_out && !ack) m_stale = 1;
      else begin m_out = 1; m_stale = 0; m_oaddr = t; end
    end else if (m_out) begin
      if (ack) begin
        if (m_stale) begin m_stale = 0; m_oaddr = m_pc; end
        else begin m_out = 0; m_held = 1; m_inst = mem(m_oaddr); end
      end
    end else if (m_held && haz) begin
      m_pc = m_pc + 32'd4; m_held = 0; m_out = 1; m_oaddr = m_pc;
    end
  endtask

  task automatic chk_model();
    chk("rnd_req", {31'b0, imem_req}, {31'b0, m_out});
    if (m_out) chk("rnd_addr", imem_addr, m_oaddr);
    chk("rnd_valid", {31'b0, inst_valid_o}, {31'b0, m_held});
    chk("rnd_inst", inst_o, m_held ? m_inst : NOP);
    if (m_held) chk("rnd_pc", pc_o, m_pc);
    chk("rnd_flush", {31'b0, IF_Flush}, {31'b0, m_flush});
`ifdef PC_MISALIGN_CHK_EN
    chk("rnd_misalign", {31'b0, misalign_o}, {31'b0, m_mis});
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'b0, inst_valid_o}, 32'd0);
    chk({tag, "_inst"}, inst_o, NOP);
    chk({tag, "_pc"}, pc_o, 32'h0);
    chk({tag, "_flush"}, {31'b0, IF_Flush}, 32'd0);
`ifdef PC_MISALIGN_CHK_EN
    chk({tag, "_misalign"}, {31'b0, misalign_o}, 32'd0);
`endif
  endtask

  task automatic drive(input bit br, input logic [31:0] tgt, input bit haz, input bit ack);
    branch_taken = br; branch_target = tgt; hazDetect_PC = haz; imem_ack = ack;
  endtask

  initial begin
    tbl[0]  = mk(0, 32'h0, 1, 0,  1, 32'h0, 0, 32'h0, 0);
    tbl[1]  = mk(0, 32'h0, 0, 1,  0, 32'h0, 1, 32'h0, 0);
    tbl[2]  = mk(0, 32'h0, 1, 0,  1, 32'h4, 0, 32'h0, 0);
    tbl[3]  = mk(0, 32'h0, 1, 0,  1, 32'h4, 0, 32'h0, 0);
    tbl[4]  = mk(0, 32'h0, 1, 0,  1, 32'h4, 0, 32'h0, 0);
    tbl[5]  = mk(0, 32'h0, 1, 0,  1, 32'h4, 0, 32'h0, 0);
    tbl[6]  = mk(0, 32'h0, 0, 1,  0, 32'h0, 1, 32'h4, 0);
    tbl[7]  = mk(0, 32'h0, 1, 0,  1, 32'h8, 0, 32'h0, 0);
    tbl[8]  = mk(0, 32'h0, 0, 1,  0, 32'h0, 1, 32'h8, 0);
    tbl[9]  = mk(0, 32'h0, 0, 0,  0, 32'h0, 1, 32'h8, 0);
    tbl[10] = mk(0, 32'h0, 0, 0,  0, 32'h0, 1, 32'h8, 0);
    tbl[11] = mk(0, 32'h0, 0, 0,  0, 32'h0, 1, 32'h8, 0);
    tbl[12] = mk(0, 32'h0, 1, 0,  1, 32'hC, 0, 32'h0, 0);
    tbl[13] = mk(1, 32'h100, 1, 0, 1, 32'hC, 0, 32'h0, 1);
    tbl[14] = mk(0, 32'h0, 1, 0,  1, 32'hC, 0, 32'h0, 0);
    tbl[15] = mk(1, 32'h200, 1, 0, 1, 32'hC, 0, 32'h0, 1);
    tbl[16] = mk(0, 32'h0, 1, 1,  1, 32'h200, 0, 32'h0, 0);
    tbl[17] = mk(0, 32'h0, 0, 1,  0, 32'h0, 1, 32'h200, 0);
    tbl[18] = mk(1, 32'h400, 0, 0, 1, 32'h400, 0, 32'h0, 1);
    tbl[19] = mk(1, 32'h500, 1, 1, 1, 32'h500, 0, 32'h0, 1);
    tbl[20] = mk(0, 32'h0, 0, 1,  0, 32'h0, 1, 32'h500, 0);
    tbl[21] = mk(1, 32'hFFFF_FFFC, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1);
    tbl[22] = mk(0, 32'h0, 0, 1,  0, 32'h0, 1, 32'hFFFF_FFFC, 0);
    tbl[23] = mk(0, 32'h0, 1, 0,  1, 32'h0, 0, 32'h0, 0);

    rst_n = 1'b0;
    drive(0, 32'h0, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].br, tbl[i].tgt, tbl[i].haz, tbl[i].ack);
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, tbl[i].e_valid});
      chk($sformatf("t%0d_inst", i), inst_o, tbl[i].e_valid ? mem(tbl[i].e_pc) : NOP);
      if (tbl[i].e_valid) chk($sformatf("t%0d_pc", i), pc_o, tbl[i].e_pc);
      chk($sformatf("t%0d_flush", i), {31'b0, IF_Flush}, {31'b0, tbl[i].e_flush});
      @(negedge clk);
    end

    // Asynchronous reset in the middle of an outstanding request (0x0).
    rst_n = 1'b0;
    #1 chk_reset_outputs("midreq_rst");
    #1 rst_n = 1'b1;

    // Misaligned redirect taken straight out of IDLE.
    drive(1, 32'h102, 1, 0);
    @(posedge clk);
    #1;
`ifdef PC_MISALIGN_CHK_EN
    chk("mis_req", {31'b0, imem_req}, 32'd0);
    chk("mis_flag", {31'b0, misalign_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 32'h200, 1, 1);
      @(posedge clk);
      #1;
      chk("halt_req", {31'b0, imem_req}, 32'd0);
      chk("halt_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("halt_flag", {31'b0, misalign_o}, 32'd1);
    end
`else
    chk("mask_req", {31'b0, imem_req}, 32'd1);
    chk("mask_addr", imem_addr, 32'h100);
    chk("mask_flush", {31'b0, IF_Flush}, 32'd1);
    @(negedge clk);
    drive(0, 32'h0, 0, 1);
    @(posedge clk);
    #1;
    chk("mask_pc", pc_o, 32'h100);
    chk("mask_inst", inst_o, mem(32'h100));
`endif

    // Randomised run against the reference model.
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #1 chk_model();
    #1 rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] t;
      bit          br, hz, ak;
      if ($urandom_range(0, 299) == 0 || (m_halt && $urandom_range(0, 7) == 0)) begin
        rst_n = 1'b0;
        m_reset();
        #1 chk_model();
        #1 rst_n = 1'b1;
      end
      br = ($urandom_range(0, 7) == 0);
      t  = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 31) == 0) t = t | ($urandom & 32'h3);
      if ($urandom_range(0, 63) == 0) t = t | 32'hFFFF_0000;
      hz = ($urandom_range(0, 3) != 0);
      ak = imem_req && ($urandom_range(0, 1) == 1);
      drive(br, t, hz, ak);
      @(posedge clk);
      m_step(br, t, hz, ak);
      #1 chk_model();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
